// File: rtl/iob_cache_traffic_gen.sv
// IOb native traffic generator: writes a MULT*addr pattern to NWORDS words, idles for a gap,
// then reads every word back and reports mismatches, first failing address and timeout.
module iob_cache_traffic_gen #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 32,
  parameter int BASE_ADDR  = 0,
  parameter int NWORDS     = 5,
  parameter int MULT       = 3,
  parameter int GAP_CYCLES = 8,
  parameter int TIMEOUT    = 1024,
  parameter int ERR_W      = 8
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic                timeout_o,
  output logic [ERR_W-1:0]    err_cnt_o,
  output logic [ADDR_W-1:0]   first_err_addr_o,
  output logic                iob_valid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_rvalid_i,
  input  logic [DATA_W-1:0]   iob_rdata_i,
  input  logic                iob_ready_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TO_W   = $clog2(TIMEOUT);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(STRB_W);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NWORDS - 1);
  localparam logic [GAP_W-1:0]  LAST_GAP = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TO_W-1:0]   LAST_TO  = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WRITE, GAP, RD_REQ, RD_WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic                valid_d, busy_d, done_d, pass_d, timeout_d;
  logic [ADDR_W-1:0]   addr_d, fea_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [STRB_W-1:0]   wstrb_d;
  logic [ERR_W-1:0]    err_d;
  logic                begin_read, finish, timed_out;

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] ax;
    ax = DATA_W'(a);
    return DATA_W'(MULT) * ax;
  endfunction

  // Next-state and next-output logic; every output is taken from a register.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    to_d       = to_q;
    valid_d    = iob_valid_o;
    addr_d     = iob_addr_o;
    wdata_d    = iob_wdata_o;
    wstrb_d    = iob_wstrb_o;
    busy_d     = busy_o;
    done_d     = 1'b0;
    pass_d     = pass_o;
    timeout_d  = timeout_o;
    err_d      = err_cnt_o;
    fea_d      = first_err_addr_o;
    begin_read = 1'b0;
    finish     = 1'b0;
    timed_out  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = WRITE;
          idx_d     = '0;
          to_d      = '0;
          valid_d   = 1'b1;
          addr_d    = BASE;
          wdata_d   = pattern(BASE);
          wstrb_d   = '1;
          busy_d    = 1'b1;
          err_d     = '0;
          fea_d     = '0;
          timeout_d = 1'b0;
          pass_d    = 1'b0;
        end
      end
      WRITE: begin
        if (iob_ready_i) begin
          to_d = '0;
          if (idx_q == LAST_IDX) begin
            if (GAP_CYCLES == 0) begin
              begin_read = 1'b1;
            end else begin
              state_d = GAP;
              gap_d   = '0;
              valid_d = 1'b0;
              wstrb_d = '0;
              wdata_d = '0;
            end
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            addr_d  = iob_addr_o + STEP;
            wdata_d = pattern(iob_addr_o + STEP);
          end
        end else if (to_q == LAST_TO) begin
          timed_out = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      GAP: begin
        if (gap_q == LAST_GAP) begin_read = 1'b1;
        else gap_d = gap_q + GAP_W'(1);
      end
      RD_REQ: begin
        if (iob_ready_i) begin
          state_d = RD_WAIT;
          valid_d = 1'b0;
          to_d    = '0;
        end else if (to_q == LAST_TO) begin
          timed_out = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      RD_WAIT: begin
        if (iob_rvalid_i) begin
          to_d = '0;
          if (iob_rdata_i != pattern(iob_addr_o)) begin
            if (err_cnt_o != '1) err_d = err_cnt_o + ERR_W'(1);
            if (err_cnt_o == '0) fea_d = iob_addr_o;
          end
          if (idx_q == LAST_IDX) begin
            finish = 1'b1;
          end else begin
            state_d = RD_REQ;
            idx_d   = idx_q + IDX_W'(1);
            addr_d  = iob_addr_o + STEP;
            valid_d = 1'b1;
          end
        end else if (to_q == LAST_TO) begin
          timed_out = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (begin_read) begin
      state_d = RD_REQ;
      idx_d   = '0;
      to_d    = '0;
      addr_d  = BASE;
      valid_d = 1'b1;
      wstrb_d = '0;
      wdata_d = '0;
    end

    if (timed_out) begin
      timeout_d = 1'b1;
      finish    = 1'b1;
    end

    // Pass is judged on the final error count, including a mismatch seen this cycle.
    if (finish) begin
      state_d = DONE;
      valid_d = 1'b0;
      to_d    = '0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      pass_d  = (err_d == '0) && !timeout_d;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q          <= IDLE;
      idx_q            <= '0;
      gap_q            <= '0;
      to_q             <= '0;
      iob_valid_o      <= 1'b0;
      iob_addr_o       <= '0;
      iob_wdata_o      <= '0;
      iob_wstrb_o      <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      pass_o           <= 1'b0;
      timeout_o        <= 1'b0;
      err_cnt_o        <= '0;
      first_err_addr_o <= '0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      gap_q            <= gap_d;
      to_q             <= to_d;
      iob_valid_o      <= valid_d;
      iob_addr_o       <= addr_d;
      iob_wdata_o      <= wdata_d;
      iob_wstrb_o      <= wstrb_d;
      busy_o           <= busy_d;
      done_o           <= done_d;
      pass_o           <= pass_d;
      timeout_o        <= timeout_d;
      err_cnt_o        <= err_d;
      first_err_addr_o <= fea_d;
    end
  end

endmodule

// File: tb/tb_iob_cache_traffic_gen.sv
// Scoreboard bench for iob_cache_traffic_gen: a slave model answers requests while a monitor
// pops expected requests and end-of-run status from queues filled by the stimulus process.
module tb_iob_cache_traffic_gen;

  typedef struct packed {
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct packed {
    logic        pass;
    logic        tmo;
    logic [7:0]  err;
    logic [23:0] fea;
  } stat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main instance (default parameters)
  logic        start, busy, done, pass, tmo, valid, rvalid, ready;
  logic [7:0]  err;
  logic [23:0] fea, addr;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;

  iob_cache_traffic_gen dut (
    .clk_i(clk), .arst_n_i(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
    .pass_o(pass), .timeout_o(tmo), .err_cnt_o(err), .first_err_addr_o(fea),
    .iob_valid_o(valid), .iob_addr_o(addr), .iob_wdata_o(wdata), .iob_wstrb_o(wstrb),
    .iob_rvalid_i(rvalid), .iob_rdata_i(rdata), .iob_ready_i(ready)
  );

  // Small instance exercising address wrap
  logic        start_b, busy_b, done_b, pass_b, tmo_b, valid_b, rvalid_b;
  logic        ready_b = 1'b1;
  logic [7:0]  err_b;
  logic [4:0]  fea_b, addr_b;
  logic [31:0] wdata_b, rdata_b;
  logic [3:0]  wstrb_b;

  iob_cache_traffic_gen #(
    .ADDR_W(5), .BASE_ADDR(24), .NWORDS(4), .GAP_CYCLES(2), .TIMEOUT(16)
  ) dut_b (
    .clk_i(clk), .arst_n_i(rst_n), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
    .pass_o(pass_b), .timeout_o(tmo_b), .err_cnt_o(err_b), .first_err_addr_o(fea_b),
    .iob_valid_o(valid_b), .iob_addr_o(addr_b), .iob_wdata_o(wdata_b), .iob_wstrb_o(wstrb_b),
    .iob_rvalid_i(rvalid_b), .iob_rdata_i(rdata_b), .iob_ready_i(ready_b)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int cycle    = 0;

  req_t  exp_q[$];
  stat_t stat_q[$];
  req_t  expb_q[$];
  stat_t statb_q[$];
  int    hs_cycles[$];

  int done_cnt = 0, done_b_cnt = 0, wr_hs = 0, stall_cycles = 0;

  int unsigned ADDR_TBL[5]  = '{0, 4, 8, 12, 16};
  int unsigned WDATA_TBL[5] = '{0, 12, 24, 36, 48};
  int unsigned ADDRB_TBL[4] = '{24, 28, 0, 4};
  int unsigned DATAB_TBL[4] = '{72, 84, 0, 12};

  // Slave behaviour knobs
  int          stall_max = 0;
  int          lat_max   = 1;
  logic        force_low = 1'b0;
  logic        no_rvalid = 1'b0;
  logic [31:0] corrupt_mask = '0;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  function automatic stat_t mkStat(input logic p, input logic t, input logic [7:0] e, input logic [23:0] a);
    stat_t s;
    s.pass = p; s.tmo = t; s.err = e; s.fea = a;
    return s;
  endfunction

  // Slave for the main instance; reacts just after each edge so its outputs are settled for the next.
  logic [31:0] mem [32];
  logic        rd_pend, p_valid;
  logic [23:0] rd_addr, p_addr;
  logic [31:0] p_wdata;
  logic [3:0]  p_wstrb;
  int          rd_delay, stall;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      rd_pend = 1'b0; rvalid = 1'b0; rdata = '0; stall = 0; ready = 1'b1; p_valid = 1'b0;
    end else begin
      rvalid = 1'b0;
      if (p_valid && ready) begin
        if (p_wstrb != 4'h0) mem[p_addr[6:2]] = p_wdata;
        else begin
          rd_pend  = 1'b1;
          rd_addr  = p_addr;
          rd_delay = int'($urandom_range(lat_max, 1)) - 1;
        end
        stall = int'($urandom_range(stall_max, 0));
      end
      if (rd_pend && !no_rvalid) begin
        if (rd_delay == 0) begin
          rvalid  = 1'b1;
          rdata   = mem[rd_addr[6:2]] ^ {31'd0, corrupt_mask[rd_addr[6:2]]};
          rd_pend = 1'b0;
        end else rd_delay--;
      end
      if (force_low) ready = 1'b0;
      else if (stall > 0) begin ready = 1'b0; stall--; end
      else ready = 1'b1;
      p_valid = valid; p_addr = addr; p_wdata = wdata; p_wstrb = wstrb;
    end
  end

  // Monitor for the main instance
  req_t  m_exp, m_prev;
  stat_t m_stat;
  logic  m_stalled = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_stalled && valid) begin
        checkOutput("stable_addr", addr, m_prev.addr);
        checkOutput("stable_wdata", wdata, m_prev.wdata);
        checkOutput("stable_wstrb", wstrb, m_prev.wstrb);
      end
      if (valid && ready) begin
        hs_cycles.push_back(cycle);
        if (wstrb != 4'h0) wr_hs++;
        if (exp_q.size() == 0) begin
          n_checks++; n_fails++;
          $display("[TB] FAIL req_unexpected: actual addr 0x%0h wstrb 0x%0h, required no request", addr, wstrb);
        end else begin
          m_exp = exp_q.pop_front();
          checkOutput("req_addr", addr, m_exp.addr);
          checkOutput("req_wdata", wdata, m_exp.wdata);
          checkOutput("req_wstrb", wstrb, m_exp.wstrb);
        end
      end
      if (valid && !ready) stall_cycles++;
      m_stalled = valid && !ready;
      m_prev.addr = addr; m_prev.wdata = wdata; m_prev.wstrb = wstrb;
      if (done) begin
        done_cnt++;
        checkOutput("valid_at_done", valid, 0);
        checkOutput("busy_at_done", busy, 0);
        if (stat_q.size() == 0) begin
          n_checks++; n_fails++;
          $display("[TB] FAIL done_unexpected: actual done=1, required no done pulse");
        end else begin
          m_stat = stat_q.pop_front();
          checkOutput("status_pass", pass, m_stat.pass);
          checkOutput("status_timeout", tmo, m_stat.tmo);
          checkOutput("status_err_cnt", err, m_stat.err);
          checkOutput("status_first_err_addr", fea, m_stat.fea);
        end
      end
    end else m_stalled = 1'b0;
  end

  // Always-ready, one-cycle-latency slave and monitor for the wrap instance
  logic [31:0] mem_b [8];
  logic        pb_valid;
  logic [4:0]  pb_addr;
  logic [31:0] pb_wdata;
  logic [3:0]  pb_wstrb;
  req_t        mb_exp;
  stat_t       mb_stat;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      rvalid_b = 1'b0; rdata_b = '0; pb_valid = 1'b0;
    end else begin
      rvalid_b = 1'b0;
      if (pb_valid) begin
        if (pb_wstrb != 4'h0) mem_b[pb_addr[4:2]] = pb_wdata;
        else begin rvalid_b = 1'b1; rdata_b = mem_b[pb_addr[4:2]]; end
      end
      pb_valid = valid_b; pb_addr = addr_b; pb_wdata = wdata_b; pb_wstrb = wstrb_b;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_b && ready_b) begin
        if (expb_q.size() == 0) begin
          n_checks++; n_fails++;
          $display("[TB] FAIL wrap_req_unexpected: actual addr 0x%0h, required no request", addr_b);
        end else begin
          mb_exp = expb_q.pop_front();
          checkOutput("wrap_req_addr", 24'(addr_b), mb_exp.addr);
          checkOutput("wrap_req_wdata", wdata_b, mb_exp.wdata);
          checkOutput("wrap_req_wstrb", wstrb_b, mb_exp.wstrb);
        end
      end
      if (done_b) begin
        done_b_cnt++;
        if (statb_q.size() == 0) begin
          n_checks++; n_fails++;
          $display("[TB] FAIL wrap_done_unexpected: actual done=1, required no done pulse");
        end else begin
          mb_stat = statb_q.pop_front();
          checkOutput("wrap_pass", pass_b, mb_stat.pass);
          checkOutput("wrap_err_cnt", err_b, mb_stat.err);
          checkOutput("wrap_timeout", tmo_b, mb_stat.tmo);
        end
      end
    end
  end

  // Queues the expected requests/status of one run, then pulses start for one cycle.
  task automatic applyStimulus(input int n_wr, input int n_rd, input bit with_stat, input stat_t st);
    req_t r;
    for (int i = 0; i < n_wr; i++) begin
      r.addr = 24'(ADDR_TBL[i]); r.wdata = WDATA_TBL[i]; r.wstrb = 4'hF;
      exp_q.push_back(r);
    end
    for (int i = 0; i < n_rd; i++) begin
      r.addr = 24'(ADDR_TBL[i]); r.wdata = '0; r.wstrb = 4'h0;
      exp_q.push_back(r);
    end
    if (with_stat) stat_q.push_back(st);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic waitDone(input int budget, input string name);
    int base;
    bit seen;
    base = done_cnt; seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(posedge clk);
      if (done_cnt != base) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fails++;
      $display("[TB] FAIL %s: actual no done pulse in %0d cycles, required one", name, budget);
    end
  endtask

  task automatic waitWrites(input int target, input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(posedge clk);
      if (wr_hs >= target) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fails++;
      $display("[TB] FAIL %s: actual %0d writes accepted, required %0d", name, wr_hs, target);
    end
  endtask

  int hb, sbase, dbase;
  req_t rb;

  initial begin
    start = 1'b0; start_b = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_outputs", {valid, busy, done, pass, tmo, err, fea, addr, wdata, wstrb}, '0);
    checkOutput("reset_outputs_b", {valid_b, busy_b, done_b, pass_b, tmo_b, err_b}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] basic pass: zero-wait slave");
    hb = hs_cycles.size();
    applyStimulus(5, 5, 1'b1, mkStat(1'b1, 1'b0, 8'd0, 24'd0));
    checkOutput("busy_after_start", busy, 1);
    waitDone(300, "basic_done");
    if (hs_cycles.size() >= hb + 6) begin
      for (int i = 1; i < 5; i++)
        checkOutput("write_back_to_back", hs_cycles[hb+i] - hs_cycles[hb+i-1], 1);
      checkOutput("gap_to_first_read", hs_cycles[hb+5] - hs_cycles[hb+4], 9);
    end else begin
      n_checks++; n_fails++;
      $display("[TB] FAIL basic_handshakes: actual %0d handshakes, required 10", hs_cycles.size() - hb);
    end
    checkOutput("basic_queue_empty", exp_q.size(), 0);

    $display("[TB] single mismatch at 8");
    corrupt_mask = 32'h4;
    applyStimulus(5, 5, 1'b1, mkStat(1'b0, 1'b0, 8'd1, 24'd8));
    waitDone(300, "err1_done");

    $display("[TB] mismatches at 8 and 16");
    corrupt_mask = 32'h14;
    applyStimulus(5, 5, 1'b1, mkStat(1'b0, 1'b0, 8'd2, 24'd8));
    waitDone(300, "err2_done");
    corrupt_mask = '0;

    $display("[TB] ready held low on third write");
    sbase = stall_cycles;
    applyStimulus(2, 0, 1'b1, mkStat(1'b0, 1'b1, 8'd0, 24'd0));
    waitWrites(wr_hs + 2 - (wr_hs % 1), 50, "tmo_first_writes");
    force_low = 1'b1;
    waitDone(1500, "tmo_write_done");
    checkOutput("tmo_write_wait_cycles", stall_cycles - sbase, 1024);
    checkOutput("tmo_write_flag", tmo, 1);
    repeat (470) @(posedge clk);
    force_low = 1'b0;
    checkOutput("tmo_write_queue_empty", exp_q.size(), 0);

    $display("[TB] rvalid never returned");
    no_rvalid = 1'b1;
    applyStimulus(5, 1, 1'b1, mkStat(1'b0, 1'b1, 8'd0, 24'd0));
    waitDone(1500, "tmo_read_done");
    checkOutput("tmo_read_valid_low", valid, 0);
    no_rvalid = 1'b0;
    repeat (5) @(posedge clk);
    checkOutput("tmo_read_queue_empty", exp_q.size(), 0);

    $display("[TB] random stalls with start pulsed while busy");
    stall_max = 5; lat_max = 4;
    dbase = done_cnt;
    applyStimulus(5, 5, 1'b1, mkStat(1'b1, 1'b0, 8'd0, 24'd0));
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    waitDone(400, "random_done");
    repeat (30) @(posedge clk);
    checkOutput("random_single_done", done_cnt - dbase, 1);
    checkOutput("random_no_restart", busy, 0);
    checkOutput("random_queue_empty", exp_q.size(), 0);
    stall_max = 0; lat_max = 1;

    $display("[TB] asynchronous reset mid write");
    applyStimulus(2, 0, 1'b0, mkStat(1'b0, 1'b0, 8'd0, 24'd0));
    waitWrites(wr_hs + 2, 50, "rst_first_writes");
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrun_reset_valid", valid, 0);
    checkOutput("midrun_reset_outputs", {valid, busy, done, pass, tmo, err, fea, addr, wdata, wstrb}, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst_queue_empty", exp_q.size() + stat_q.size(), 0);
    applyStimulus(5, 5, 1'b1, mkStat(1'b1, 1'b0, 8'd0, 24'd0));
    waitDone(300, "post_reset_done");

    $display("[TB] address wrap instance");
    for (int i = 0; i < 4; i++) begin
      rb.addr = 24'(ADDRB_TBL[i]); rb.wdata = DATAB_TBL[i]; rb.wstrb = 4'hF;
      expb_q.push_back(rb);
    end
    for (int i = 0; i < 4; i++) begin
      rb.addr = 24'(ADDRB_TBL[i]); rb.wdata = '0; rb.wstrb = 4'h0;
      expb_q.push_back(rb);
    end
    statb_q.push_back(mkStat(1'b1, 1'b0, 8'd0, 24'd0));
    dbase = done_b_cnt;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    for (int k = 0; k < 200 && done_b_cnt == dbase; k++) @(posedge clk);
    checkOutput("wrap_done_seen", done_b_cnt - dbase, 1);
    checkOutput("wrap_queue_empty", expb_q.size() + statb_q.size(), 0);

    repeat (3) @(posedge clk);
    checkOutput("final_queues_empty", exp_q.size() + stat_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/iob_cache_traffic_gen.md
Name: iob_cache_traffic_gen

Overview:
- Hardware IOb native master that sits directly upstream of the iob_cache frontend and drives its valid/addr/wdata/wstrb/ready/rvalid/rdata port.
- On a start pulse it runs three phases: write a deterministic pattern to NWORDS consecutive words, wait a programmable gap, then read every word back one at a time.
- Each read is checked against the pattern, and the block reports pass/fail, error count, first failing address and timeout.
- Used for self-checking cache simulation and FPGA bring-up without a CPU.

Parameters:
ADDR_W, 24, byte address width of iob_addr_o
DATA_W, 32, data width; DATA_W/8 bytes per word
BASE_ADDR, 0, first byte address; must be word aligned
NWORDS, 5, number of words written and read per run (>=1)
MULT, 3, pattern multiplier: data = (MULT*addr) mod 2^DATA_W
GAP_CYCLES, 8, idle cycles between last write acceptance and first read request
TIMEOUT, 1024, max cycles waiting for ready or rvalid before abort (>=2)
ERR_W, 8, width of error counter

Ports:
clk_i  in  1  clock
arst_n_i  in  1  asynchronous active-low reset
start_i  in  1  single-cycle run request; ignored while busy_o=1
busy_o  out  1  high from cycle after accepted start until done
done_o  out  1  one-cycle pulse at run end (normal or timeout)
pass_o  out  1  sticky: 1 if last run had no errors and no timeout
timeout_o  out  1  sticky: last run aborted on timeout
err_cnt_o  out  ERR_W  mismatches in last run, saturating
first_err_addr_o  out  ADDR_W  byte address of first mismatch of last run
iob_valid_o  out  1  request valid
iob_addr_o  out  ADDR_W  byte address, word aligned
iob_wdata_o  out  DATA_W  write data
iob_wstrb_o  out  DATA_W/8  write strobe; all ones = write, zero = read
iob_rvalid_i  in  1  read data valid
iob_rdata_i  in  DATA_W  read data
iob_ready_i  in  1  request accepted when valid_o & ready_i at posedge

Behaviour:
Reset and register rules:
- All outputs are registered. On arst_n_i=0 every output is 0 and the FSM is in IDLE, regardless of phase.
- Reset mid-transaction drops iob_valid_o immediately (asynchronous); no partial state survives.

FSM states: IDLE, WRITE, GAP, RD_REQ, RD_WAIT, DONE.
- IDLE: start_i=1 -> WRITE. On entry: idx=0, addr=BASE_ADDR, err_cnt=0, first_err_addr=0, timeout=0, pass=0; busy_o=1.
- WRITE: valid_o=1, wstrb=all ones, wdata=MULT*addr. On accept: idx+1, addr += DATA_W/8, and valid stays high with the next word (back-to-back, zero bubble). On accept of the last word -> GAP with valid_o=0.
- GAP: counts GAP_CYCLES cycles, then -> RD_REQ with addr=BASE_ADDR, idx=0. GAP_CYCLES=0 goes directly to RD_REQ the cycle after the last write is accepted.
- RD_REQ: valid_o=1, wstrb=0, wdata=0. On accept -> RD_WAIT, valid_o=0 next cycle. Only one outstanding read.
- RD_WAIT: on rvalid_i, compare rdata_i to MULT*addr (DATA_W bits).
  - Mismatch: err_cnt+1, saturating at 2^ERR_W-1. On the first mismatch, first_err_addr=addr.
  - Then idx+1, addr += DATA_W/8. If more words remain -> RD_REQ, with valid high the following cycle; otherwise -> DONE.
- rvalid_i is sampled only in RD_WAIT; rvalid in any other state is ignored. Minimum read latency accepted is 1 cycle after acceptance.
- DONE: done_o=1 for one cycle, busy_o=0, pass_o=(err_cnt==0 && !timeout). Then -> IDLE.

Timing and arithmetic:
- Addresses wrap modulo 2^ADDR_W; the product MULT*addr is truncated to DATA_W.
- A timeout counter resets on every state change and every handshake, and increments while waiting in WRITE, RD_REQ or RD_WAIT. Reaching TIMEOUT sets timeout_o=1, drops valid_o, and goes -> DONE.
- iob_addr_o, iob_wdata_o and iob_wstrb_o are stable while valid_o=1 and ready_i=0.
- start_i while busy is ignored. start_i in the same cycle as DONE is ignored; it is accepted from IDLE only.
- Status outputs hold their values until the next accepted start.

Test Plan:
- Defaults, slave ready always high, rvalid 1 cycle after accept -> writes to addr 0,4,8,12,16 with data 0,12,24,36,48 back-to-back in 5 cycles; 8 gap cycles; 5 reads; done_o pulse; pass_o=1, err_cnt_o=0.
- Slave flips bit 0 of read data at addr 8 -> err_cnt_o=1, first_err_addr_o=8, pass_o=0. Errors at 8 and 16 -> err_cnt_o=2, first_err_addr_o=8.
- ready_i held low 1500 cycles during the third write -> timeout_o=1, done_o pulse at cycle 1024 of waiting, valid_o=0, pass_o=0. Also: rvalid never returned -> same result.
- Random ready stalls 0-5 cycles and rvalid latency 1-4 cycles -> addr/wdata/wstrb stable during stalls, pass_o=1; start_i pulsed while busy -> no restart, single done_o.
- arst_n_i pulsed low mid write phase -> all outputs 0 immediately; a subsequent start runs a full pass with pass_o=1.
- ADDR_W=5, BASE_ADDR=24, NWORDS=4 -> addresses 24,28,0,4 and data 72,84,0,12; pass_o=1.
